// File: rtl/time_set_entry_if.sv
// Signal bundle between the time-entry controller and its surroundings:
// debounced buttons and live counter digits in, edited digits, load strobe,
// run enable, blink mask and state out.
interface time_set_entry_if;
  logic       mode_btn;
  logic       inc_btn;
  logic       dec_btn;
  logic [3:0] cur_min_ten;
  logic [3:0] cur_min_one;
  logic [3:0] cur_sec_ten;
  logic [3:0] cur_sec_one;
  logic [3:0] set_min_ten;
  logic [3:0] set_min_one;
  logic [3:0] set_sec_ten;
  logic [3:0] set_sec_one;
  logic       load_pulse;
  logic       running;
  logic [3:0] blink_mask;
  logic [1:0] state;

  // Environment side: buttons and live digits out, controller results in.
  modport master (
    output mode_btn, inc_btn, dec_btn,
    output cur_min_ten, cur_min_one, cur_sec_ten, cur_sec_one,
    input  set_min_ten, set_min_one, set_sec_ten, set_sec_one,
    input  load_pulse, running, blink_mask, state
  );

  // Controller side.
  modport slave (
    input  mode_btn, inc_btn, dec_btn,
    input  cur_min_ten, cur_min_one, cur_sec_ten, cur_sec_one,
    output set_min_ten, set_min_one, set_sec_ten, set_sec_one,
    output load_pulse, running, blink_mask, state
  );
endinterface

// File: rtl/time_set_entry.sv
// Time-entry controller for the mm:ss counter. Captures the live time, lets
// the user edit minutes then seconds in BCD with hold-to-repeat, and hands
// the result back to the counter with a one-tick load strobe.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   RUN     | counter free-running, buttons other than mode ignored
//   SET_MIN | editing minutes, counter paused, minute digits blink
//   SET_SEC | editing seconds, counter paused, second digits blink
//   COMMIT  | single tick, load_pulse high, back to RUN next tick
module time_set_entry #(
  parameter int HOLD_TICKS    = 4,
  parameter int TIMEOUT_TICKS = 40
) (
  input logic             clk4hz,
  input logic             reset,
  time_set_entry_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_MIN = 2'b01,
    SET_SEC = 2'b10,
    COMMIT  = 2'b11
  } state_t;

  // Hold counter saturates at the first repeating tick; every tick at the
  // saturation value produces one step.
  localparam int HW = $clog2(HOLD_TICKS + 3);
  localparam int IW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [HW-1:0] HOLD_SAT     = HW'(HOLD_TICKS + 2);
  localparam logic [IW-1:0] IDLE_LAST    = IW'(TIMEOUT_TICKS - 1);
  localparam logic [3:0]    MASK_MIN     = 4'b1100;
  localparam logic [3:0]    MASK_SEC     = 4'b0011;

  state_t        state_q;
  logic [3:0]    min_ten_q, min_one_q, sec_ten_q, sec_one_q;
  logic          load_q;
  logic          running_q;
  logic [3:0]    mask_q;
  logic          phase_q;
  logic [HW-1:0] hold_q;
  logic [IW-1:0] idle_q;
  logic          mode_prev, inc_prev, dec_prev;

  logic          mode_press, inc_press, dec_press;
  logic          editing;
  logic          single_btn;
  logic          active_press;
  logic [HW-1:0] hold_next;
  logic          step;
  logic          repeat_active;
  logic          idle_tick;
  logic          timeout_hit;
  logic [3:0]    field_ten, field_one;
  logic [7:0]    field_stepped;
  logic [3:0]    edit_mask;

  // Two-digit BCD increment over 00..59 with wrap to 00.
  function automatic logic [7:0] bcd59_inc(input logic [3:0] ten, input logic [3:0] one);
    logic [3:0] t, o;
    if (one == 4'd9) begin
      o = 4'd0;
      t = (ten == 4'd5) ? 4'd0 : ten + 4'd1;
    end else begin
      o = one + 4'd1;
      t = ten;
    end
    return {t, o};
  endfunction

  // Two-digit BCD decrement over 00..59 with wrap to 59.
  function automatic logic [7:0] bcd59_dec(input logic [3:0] ten, input logic [3:0] one);
    logic [3:0] t, o;
    if (one == 4'd0) begin
      o = 4'd9;
      t = (ten == 4'd0) ? 4'd5 : ten - 4'd1;
    end else begin
      o = one - 4'd1;
      t = ten;
    end
    return {t, o};
  endfunction

  // Edge detection, hold/repeat decision, idle timeout and the edited field.
  always_comb begin
    mode_press = bus.mode_btn & ~mode_prev;
    inc_press  = bus.inc_btn  & ~inc_prev;
    dec_press  = bus.dec_btn  & ~dec_prev;

    editing    = (state_q == SET_MIN) || (state_q == SET_SEC);
    single_btn = bus.inc_btn ^ bus.dec_btn;
    active_press = bus.inc_btn ? inc_press : dec_press;

    // A button already held when editing began never starts a repeat run
    // unless it is released and pressed again.
    hold_next = '0;
    if (editing && !mode_press && single_btn) begin
      if (active_press)
        hold_next = HW'(1);
      else if (hold_q == HOLD_SAT)
        hold_next = HOLD_SAT;
      else if (hold_q != '0)
        hold_next = hold_q + HW'(1);
    end

    step          = (hold_next == HW'(1)) || (hold_next == HOLD_SAT);
    repeat_active = (hold_next == HOLD_SAT);

    idle_tick   = editing && !(bus.mode_btn || bus.inc_btn || bus.dec_btn);
    timeout_hit = idle_tick && (idle_q == IDLE_LAST);

    if (state_q == SET_MIN) begin
      field_ten = min_ten_q;
      field_one = min_one_q;
      edit_mask = MASK_MIN;
    end else begin
      field_ten = sec_ten_q;
      field_one = sec_one_q;
      edit_mask = MASK_SEC;
    end

    field_stepped = bus.inc_btn ? bcd59_inc(field_ten, field_one)
                                : bcd59_dec(field_ten, field_one);
  end

  // Mode FSM with registered outputs, edit datapath and tick counters.
  always_ff @(posedge clk4hz) begin
    if (reset) begin
      state_q   <= RUN;
      min_ten_q <= 4'd0;
      min_one_q <= 4'd0;
      sec_ten_q <= 4'd0;
      sec_one_q <= 4'd0;
      load_q    <= 1'b0;
      running_q <= 1'b1;
      mask_q    <= 4'd0;
      phase_q   <= 1'b0;
      hold_q    <= '0;
      idle_q    <= '0;
      mode_prev <= 1'b1;
      inc_prev  <= 1'b1;
      dec_prev  <= 1'b1;
    end else begin
      mode_prev <= bus.mode_btn;
      inc_prev  <= bus.inc_btn;
      dec_prev  <= bus.dec_btn;
      hold_q    <= hold_next;

      case (state_q)
        RUN: begin
          load_q    <= 1'b0;
          running_q <= 1'b1;
          mask_q    <= 4'd0;
          phase_q   <= 1'b0;
          idle_q    <= '0;
          if (mode_press) begin
            state_q   <= SET_MIN;
            min_ten_q <= bus.cur_min_ten;
            min_one_q <= bus.cur_min_one;
            sec_ten_q <= bus.cur_sec_ten;
            sec_one_q <= bus.cur_sec_one;
            running_q <= 1'b0;
            phase_q   <= 1'b1;
            mask_q    <= MASK_MIN;
          end
        end

        SET_MIN, SET_SEC: begin
          load_q <= 1'b0;
          if (mode_press) begin
            idle_q <= '0;
            if (state_q == SET_MIN) begin
              state_q <= SET_SEC;
              phase_q <= 1'b1;
              mask_q  <= MASK_SEC;
            end else begin
              state_q   <= COMMIT;
              load_q    <= 1'b1;
              running_q <= 1'b1;
              phase_q   <= 1'b0;
              mask_q    <= 4'd0;
            end
          end else if (timeout_hit) begin
            // Abandon the edit silently: no load, counter resumes.
            state_q   <= RUN;
            running_q <= 1'b1;
            phase_q   <= 1'b0;
            mask_q    <= 4'd0;
            idle_q    <= '0;
          end else begin
            phase_q <= ~phase_q;
            idle_q  <= idle_tick ? idle_q + IW'(1) : '0;
            mask_q  <= (repeat_active || phase_q) ? 4'd0 : edit_mask;
            if (step) begin
              if (state_q == SET_MIN) begin
                min_ten_q <= field_stepped[7:4];
                min_one_q <= field_stepped[3:0];
              end else begin
                sec_ten_q <= field_stepped[7:4];
                sec_one_q <= field_stepped[3:0];
              end
            end
          end
        end

        COMMIT: begin
          state_q   <= RUN;
          load_q    <= 1'b0;
          running_q <= 1'b1;
          mask_q    <= 4'd0;
          phase_q   <= 1'b0;
          idle_q    <= '0;
        end

        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.set_min_ten = min_ten_q;
  assign bus.set_min_one = min_one_q;
  assign bus.set_sec_ten = sec_ten_q;
  assign bus.set_sec_one = sec_one_q;
  assign bus.load_pulse  = load_q;
  assign bus.running     = running_q;
  assign bus.blink_mask  = mask_q;
  assign bus.state       = state_q;

endmodule
